dpram_fifo_ctrl: RTL and testbench

- Synchronous FIFO controller that sits directly upstream of the team's 1024x8 true-dual-port RAM and drives both of its ports.
- Port A is the write port and port B is the read port.
- It presents a valid/ready streaming interface on both sides.
- It hides the RAM's 1-cycle registered read latency behind a 2-entry output skid buffer, so the output is first-word-fall-through at full throughput.

---
 rtl/dpram_fifo_ctrl.sv | 179 +++++++++++++++++
 tb/tb_dpram_fifo_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dpram_fifo_ctrl
// Description : Synchronous FIFO controller driving a 1024x8 true-dual-port
//               RAM (port A = write, port B = read). A 2-entry skid buffer
//               absorbs the RAM's 1-cycle registered read latency, giving a
//               first-word-fall-through output at one word per cycle.
//
// Ports       : clk, rst_n          - clock, async active-low reset
//               clr                 - sync clear (only with FIFO_SYNC_CLR_EN)
//               in_valid/in_ready/in_data     - write-side stream
//               out_valid/out_ready/out_data  - read-side stream (FWFT)
//               count               - mem_cnt + rd_pend + buf_occ
//               ram_addr_a/ram_data_a/ram_we_a - RAM port A (write)
//               ram_addr_b/ram_data_b/ram_we_b - RAM port B (read only)
//               ram_q_b             - RAM port B registered read data
//
// Options     : `define FIFO_SYNC_CLR_EN adds the synchronous clr input.
//
// Revision    : 1.0 - initial release
// ============================================================================
module dpram_fifo_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef FIFO_SYNC_CLR_EN
    input  logic                clr,
`endif
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [ADDR_W+1:0]   count,
    output logic [ADDR_W-1:0]   ram_addr_a,
    output logic [DATA_W-1:0]   ram_data_a,
    output logic                ram_we_a,
    output logic [ADDR_W-1:0]   ram_addr_b,
    output logic [DATA_W-1:0]   ram_data_b,
    output logic                ram_we_b,
    input  logic [DATA_W-1:0]   ram_q_b
);

    localparam logic [ADDR_W:0] c_DEPTH = {1'b1, {ADDR_W{1'b0}}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_mem_cnt;   // words resident in RAM, 0..DEPTH
    logic              r_rd_pend;   // a RAM read issued last cycle lands now
    logic [1:0]        r_buf_occ;   // skid entries, 0..2
    logic [DATA_W-1:0] r_buf0;      // head entry
    logic [DATA_W-1:0] r_buf1;      // second entry

    logic              w_clr;
    logic              w_push;
    logic              w_pop;
    logic              w_fetch;
    logic [1:0]        w_occ_after_pop;
    logic [2:0]        w_occ_nxt;
    logic [ADDR_W:0]   w_mem_cnt_nxt;
    logic [DATA_W-1:0] w_buf0_nxt;
    logic [DATA_W-1:0] w_buf1_nxt;

`ifdef FIFO_SYNC_CLR_EN
    assign w_clr = clr;
`else
    assign w_clr = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    // in_ready stays high during clr so the producer never sees a stall
    // caused by the clear itself; the word offered then is dropped.
    assign in_ready  = (r_mem_cnt != c_DEPTH) || w_clr;
    assign w_push    = in_valid && in_ready && !w_clr;
    assign out_valid = (r_buf_occ != 2'd0);
    assign out_data  = r_buf0;
    assign w_pop     = out_valid && out_ready;

    // Entries left in the skid after this cycle's pop.
    assign w_occ_after_pop = r_buf_occ - {1'b0, w_pop};

    // Only issue a read if its word is guaranteed a skid slot when it
    // arrives next cycle: entries left after the pop plus the word already
    // in flight must leave room.
    assign w_fetch = (r_mem_cnt != '0) &&
                     (({1'b0, w_occ_after_pop} + {2'b00, r_rd_pend}) < 3'd2);

    assign w_occ_nxt = {1'b0, w_occ_after_pop} + {2'b00, r_rd_pend};

    always_comb begin
        w_mem_cnt_nxt = r_mem_cnt;
        case ({w_push, w_fetch})
            2'b10:   w_mem_cnt_nxt = r_mem_cnt + (ADDR_W+1)'(1);
            2'b01:   w_mem_cnt_nxt = r_mem_cnt - (ADDR_W+1)'(1);
            default: w_mem_cnt_nxt = r_mem_cnt;
        endcase
    end

    // Skid buffer: pop shifts entry 1 to the head, then the landing RAM
    // word is appended behind whatever remains.
    always_comb begin
        w_buf0_nxt = r_buf0;
        w_buf1_nxt = r_buf1;
        if (w_pop && (r_buf_occ == 2'd2)) begin
            w_buf0_nxt = r_buf1;
        end
        if (r_rd_pend) begin
            if (w_occ_after_pop == 2'd0) begin
                w_buf0_nxt = ram_q_b;
            end else begin
                w_buf1_nxt = ram_q_b;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_mem_cnt <= '0;
            r_rd_pend <= 1'b0;
            r_buf_occ <= 2'd0;
            r_buf0    <= '0;
            r_buf1    <= '0;
        end else if (w_clr) begin
            // Same effect as reset; a word landing on ram_q_b now is lost.
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_mem_cnt <= '0;
            r_rd_pend <= 1'b0;
            r_buf_occ <= 2'd0;
            r_buf0    <= '0;
            r_buf1    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_fetch) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            r_mem_cnt <= w_mem_cnt_nxt;
            r_rd_pend <= w_fetch;
            r_buf_occ <= w_occ_nxt[1:0];
            r_buf0    <= w_buf0_nxt;
            r_buf1    <= w_buf1_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign count = (ADDR_W+2)'(r_mem_cnt) + (ADDR_W+2)'(r_rd_pend) +
                   (ADDR_W+2)'(r_buf_occ);

    assign ram_addr_a = r_wr_ptr;
    assign ram_data_a = in_data;
    assign ram_we_a   = w_push;
    assign ram_addr_b = r_rd_ptr;
    assign ram_data_b = '0;
    assign ram_we_b   = 1'b0;

    // The fetch rule must keep the skid from ever holding a third word.
    a_skid_no_overflow : assert property (
        @(posedge clk) disable iff (!rst_n) (w_occ_nxt <= 3'd2)
    );

endmodule
`default_nettype wire

// File: tb/tb_dpram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dpram_fifo_ctrl
// Description : Self-checking bench for dpram_fifo_ctrl with a behavioural
//               1024x8 RAM, a queue-based reference FIFO and a separate
//               output monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dpram_fifo_ctrl;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clr = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W+1:0] count;
    logic [ADDR_W-1:0] ram_addr_a;
    logic [DATA_W-1:0] ram_data_a;
    logic              ram_we_a;
    logic [ADDR_W-1:0] ram_addr_b;
    logic [DATA_W-1:0] ram_data_b;
    logic              ram_we_b;
    logic [DATA_W-1:0] ram_q_b;

    dpram_fifo_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef FIFO_SYNC_CLR_EN
        .clr        (clr),
`endif
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .count      (count),
        .ram_addr_a (ram_addr_a),
        .ram_data_a (ram_data_a),
        .ram_we_a   (ram_we_a),
        .ram_addr_b (ram_addr_b),
        .ram_data_b (ram_data_b),
        .ram_we_b   (ram_we_b),
        .ram_q_b    (ram_q_b)
    );

    always #5 clk = ~clk;

    // Behavioural true-dual-port RAM with registered port-B read.
    logic [DATA_W-1:0] ram [0:DEPTH-1];
    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = '0;
        ram_q_b = '0;
    end
    always @(posedge clk) begin
        if (ram_we_a) ram[ram_addr_a] <= ram_data_a;
        if (ram_we_b) ram[ram_addr_b] <= ram_data_b;
        ram_q_b <= ram[ram_addr_b];
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    int                n_checks = 0;
    int                n_pass   = 0;
    int                n_push   = 0;
    int                n_pop    = 0;
    logic [DATA_W-1:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Stimulus side: every accepted word is queued as an expected output.
    // Occupancy must equal words accepted minus words delivered.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            n_push = 0;
            n_pop  = 0;
        end else begin
            chk("count", 32'(count), n_push - n_pop);
            if (clr) begin
                exp_q.delete();
                n_push = 0;
                n_pop  = 0;
            end else if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                n_push++;
            end
        end
    end

    // Monitor: compares every delivered word and checks output hold.
    logic              stall = 1'b0;
    logic [DATA_W-1:0] held  = '0;
    logic [DATA_W-1:0] exp_w;
    always @(negedge clk) begin
        #1;
        if (!rst_n || clr) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                chk("hold_valid", 32'(out_valid), 1);
                chk("hold_data", 32'(out_data), 32'(held));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_nonempty", exp_q.size(), 1);
                end else begin
                    exp_w = exp_q.pop_front();
                    chk("data", 32'(out_data), 32'(exp_w));
                end
                n_pop++;
            end
            stall = out_valid && !out_ready;
            held  = out_data;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus tasks
    // ------------------------------------------------------------------
    // Push one word into an empty FIFO and follow it through the latency.
    task automatic probe(input logic [DATA_W-1:0] d);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = d; out_ready = 1'b1;
        @(negedge clk);
        chk("probe_accept", 32'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("probe_valid", 32'(out_valid), (k == 2) ? 1 : 0);
            chk("probe_count", 32'(count), (k < 3) ? 1 : 0);
            if (k == 2) chk("probe_data", 32'(out_data), 32'(d));
        end
    endtask

    task automatic drain();
        int k;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        k = 0;
        while (count != 0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        chk("drain_done", 32'(count), 0);
        chk("drain_sb_empty", exp_q.size(), 0);
    endtask

    initial begin
        int acc;
        int pops_before;
        int i;

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_count", 32'(count), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("ram_we_b", 32'(ram_we_b), 0);
        chk("ram_data_b", 32'(ram_data_b), 0);

        // Single word latency and count sequence.
        probe(8'h11);

        // Fill to full capacity with the output stalled.
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 1200; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_data = 8'(acc);
            @(negedge clk);
            if (in_ready) acc++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("fill_accepted", acc, DEPTH + 2);
        chk("fill_in_ready", 32'(in_ready), 0);
        chk("fill_count", 32'(count), DEPTH + 2);
        pops_before = n_pop;
        drain();
        chk("drain_words", n_pop - pops_before, DEPTH + 2);

        // Sustained streaming with wrap-around.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; out_ready = 1'b1; in_data = 8'(c);
            @(negedge clk);
            chk("stream_in_ready", 32'(in_ready), 1);
            if (c >= 3) chk("stream_no_gap", 32'(out_valid), 1);
        end
        drain();

        // Backpressure: out_ready toggles every cycle.
        acc = 0;
        i = 0;
        while (acc < 100 && i < 1000) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_data = 8'($urandom); out_ready = i[0];
            @(negedge clk);
            if (in_ready) acc++;
            i++;
        end
        chk("bp_words", acc, 100);
        drain();

        // Random traffic.
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            in_data   = 8'($urandom);
        end

        // Load some words, then reset asynchronously between edges.
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; out_ready = 1'b0; in_data = 8'($urandom);
        end
        @(posedge clk); #3;
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_count", 32'(count), 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        probe(8'hA5);

`ifdef FIFO_SYNC_CLR_EN
        // Synchronous clear with a simultaneous push.
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_data = 8'(c + 1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
        @(negedge clk);
        chk("clr_count_before", 32'(count), 10);
        chk("clr_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("clr_count", 32'(count), 0);
        chk("clr_out_valid", 32'(out_valid), 0);
        probe(8'h3C);
`endif

        drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
